// File: rtl/uart_serializer_p.sv
// uart_serializer_p
// Parallel-to-serial shifter for the UART TX datapath. A word is captured on
// data_valid while idle, presented one bit at a time on ser_data, and advanced
// on each ser_en tick. The parity of the captured word is held on par_bit
// until the next load. The TX FSM adds start/parity/stop framing around it.
module uart_serializer_p #(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  data_valid,
  input  logic                  PAR_TYP,
  input  logic                  ser_en,
  output logic                  ser_data,
  output logic                  ser_done,
  output logic                  busy,
  output logic                  par_bit
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shreg_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_nxt;
  logic                  done_nxt;
  logic                  par_nxt;

  // State, shift register, bit counter, done pulse and parity registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      shreg    <= '0;
      cnt      <= '0;
      ser_done <= 1'b0;
      par_bit  <= 1'b0;
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      cnt      <= cnt_nxt;
      ser_done <= done_nxt;
      par_bit  <= par_nxt;
    end
  end

  // Next-state logic: load while idle, shift on ser_en ticks while shifting,
  // and return to idle with a one-cycle done pulse once the last bit is used.
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    par_nxt   = par_bit;
    case (state)
      IDLE: begin
        if (data_valid) begin
          shreg_nxt = P_DATA;
          cnt_nxt   = '0;
          par_nxt   = (^P_DATA) ^ PAR_TYP;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (ser_en) begin
          if (MSB_FIRST) begin
            shreg_nxt = {shreg[DATA_WIDTH-2:0], 1'b0};
          end else begin
            shreg_nxt = {1'b0, shreg[DATA_WIDTH-1:1]};
          end
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt == LAST_IDX) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Busy covers exactly the shifting state, so it rises the cycle after a
  // load and falls together with the done pulse.
  always_comb begin
    busy = (state == SHIFT);
  end

  // Output bit taken straight from the output end of the register; forced
  // low while idle so the line carries no stale data.
  always_comb begin
    ser_data = 1'b0;
    if (state == SHIFT) begin
      ser_data = MSB_FIRST ? shreg[DATA_WIDTH-1] : shreg[0];
    end
  end

endmodule

// File: tb/tb_uart_serializer_p.sv
// tb_uart_serializer_p
// Bench for uart_serializer_p: an 8-bit LSB-first and an 8-bit MSB-first
// instance share one stimulus stream, a 16-bit instance has its own. Expected
// bit order and parity come from a word-level model of the transmitted frame.
module tb_uart_serializer_p;

  logic       CLK_tb;
  logic       RST;
  logic [7:0] p_data8;
  logic       data_valid;
  logic       par_typ;
  logic       ser_en;
  logic       ser_data_l, ser_done_l, busy_l, par_bit_l;
  logic       ser_data_m, ser_done_m, busy_m, par_bit_m;

  logic [15:0] p_data16;
  logic        data_valid16;
  logic        par_typ16;
  logic        ser_en16;
  logic        ser_data_w, ser_done_w, busy_w, par_bit_w;

  int n_compared;
  int n_mismatched;

  uart_serializer_p #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .CLK(CLK_tb), .RST(RST), .P_DATA(p_data8), .data_valid(data_valid),
    .PAR_TYP(par_typ), .ser_en(ser_en), .ser_data(ser_data_l),
    .ser_done(ser_done_l), .busy(busy_l), .par_bit(par_bit_l)
  );

  uart_serializer_p #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .CLK(CLK_tb), .RST(RST), .P_DATA(p_data8), .data_valid(data_valid),
    .PAR_TYP(par_typ), .ser_en(ser_en), .ser_data(ser_data_m),
    .ser_done(ser_done_m), .busy(busy_m), .par_bit(par_bit_m)
  );

  uart_serializer_p #(.DATA_WIDTH(16), .MSB_FIRST(1'b0)) dut_w16 (
    .CLK(CLK_tb), .RST(RST), .P_DATA(p_data16), .data_valid(data_valid16),
    .PAR_TYP(par_typ16), .ser_en(ser_en16), .ser_data(ser_data_w),
    .ser_done(ser_done_w), .busy(busy_w), .par_bit(par_bit_w)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    CLK_tb = 1'b0;
    forever #5 CLK_tb = ~CLK_tb;
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish, actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  // Bit k of the transmitted sequence for a word of the given width.
  function automatic logic tx_bit(input logic [31:0] w, input int width, input int k, input bit msb);
    return msb ? w[width-1-k] : w[k];
  endfunction

  // Parity: even parity makes the total count of ones even, odd makes it odd.
  function automatic logic parity_of(input logic [31:0] w, input logic pt);
    return logic'(($countones(w) % 2) == 1) ^ pt;
  endfunction

  task automatic step();
    @(posedge CLK_tb);
    #1;
  endtask

  task automatic load_word8(input logic [7:0] w, input logic pt);
    p_data8    = w;
    par_typ    = pt;
    data_valid = 1'b1;
    step();
    data_valid = 1'b0;
  endtask

  // Runs one frame on both 8-bit instances (word already loaded), checking
  // every cycle, and stops in the done cycle without advancing past it.
  task automatic shift_frame8(input logic [7:0] w, input logic pt, input int period,
                              input bit noise, input logic [7:0] noise_word, input string tag);
    logic       pe;
    logic [7:0] exp_v;
    logic [7:0] act_v;
    pe = parity_of({24'h0, w}, pt);
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < period; c++) begin
        exp_v = {tx_bit({24'h0, w}, 8, k, 1'b0), tx_bit({24'h0, w}, 8, k, 1'b1),
                 1'b1, 1'b1, pe, pe, 1'b0, 1'b0};
        act_v = {ser_data_l, ser_data_m, busy_l, busy_m, par_bit_l, par_bit_m, ser_done_l, ser_done_m};
        n_compared++;
        if (act_v !== exp_v) begin
          n_mismatched++;
          $display("[TB] FAIL %s bit%0d cyc%0d {serL,serM,busyL,busyM,parL,parM,doneL,doneM}: actual=%b required=%b",
                   tag, k, c, act_v, exp_v);
        end
        data_valid = noise;
        if (noise) begin
          p_data8 = noise_word;
          par_typ = ~pt;
        end
        ser_en = (c == period - 1);
        step();
      end
    end
    data_valid = 1'b0;
    exp_v = {1'b0, 1'b0, 1'b0, 1'b0, pe, pe, 1'b1, 1'b1};
    act_v = {ser_data_l, ser_data_m, busy_l, busy_m, par_bit_l, par_bit_m, ser_done_l, ser_done_m};
    n_compared++;
    if (act_v !== exp_v) begin
      n_mismatched++;
      $display("[TB] FAIL %s done-cycle {serL,serM,busyL,busyM,parL,parM,doneL,doneM}: actual=%b required=%b",
               tag, act_v, exp_v);
    end
  endtask

  // One idle cycle after a frame: done clears, parity is held.
  task automatic idle_after8(input logic [7:0] w, input logic pt, input string tag);
    logic       pe;
    logic [7:0] exp_v;
    logic [7:0] act_v;
    pe = parity_of({24'h0, w}, pt);
    data_valid = 1'b0;
    step();
    exp_v = {1'b0, 1'b0, 1'b0, 1'b0, pe, pe, 1'b0, 1'b0};
    act_v = {ser_data_l, ser_data_m, busy_l, busy_m, par_bit_l, par_bit_m, ser_done_l, ser_done_m};
    n_compared++;
    if (act_v !== exp_v) begin
      n_mismatched++;
      $display("[TB] FAIL %s idle {serL,serM,busyL,busyM,parL,parM,doneL,doneM}: actual=%b required=%b",
               tag, act_v, exp_v);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    data_valid = 1'b1;
    ser_en = 1'b1;
    p_data8 = 8'hFF;
    par_typ = 1'b1;
    data_valid16 = 1'b1;
    ser_en16 = 1'b1;
    p_data16 = 16'hFFFF;
    par_typ16 = 1'b1;
    step();
    step();
    n_compared++;
    if ({ser_data_l, ser_data_m, busy_l, busy_m, par_bit_l, par_bit_m, ser_done_l, ser_done_m} !== 8'h00) begin
      n_mismatched++;
      $display("[TB] FAIL reset8 outputs: actual=%b required=%b",
               {ser_data_l, ser_data_m, busy_l, busy_m, par_bit_l, par_bit_m, ser_done_l, ser_done_m}, 8'h00);
    end
    n_compared++;
    if ({ser_data_w, busy_w, par_bit_w, ser_done_w} !== 4'h0) begin
      n_mismatched++;
      $display("[TB] FAIL reset16 outputs: actual=%b required=%b",
               {ser_data_w, busy_w, par_bit_w, ser_done_w}, 4'h0);
    end
    data_valid = 1'b0;
    ser_en = 1'b0;
    data_valid16 = 1'b0;
    ser_en16 = 1'b0;
    RST = 1'b0;
    step();
  endtask

  task automatic test_order_parity();
    load_word8(8'hB3, 1'b0);
    shift_frame8(8'hB3, 1'b0, 1, 1'b0, 8'h00, "B3_even");
    load_word8(8'hB3, 1'b1);
    shift_frame8(8'hB3, 1'b1, 1, 1'b0, 8'h00, "B3_odd");
    idle_after8(8'hB3, 1'b1, "B3_odd");
  endtask

  task automatic test_gated();
    ser_en = 1'b0;
    load_word8(8'h0F, 1'b0);
    shift_frame8(8'h0F, 1'b0, 4, 1'b0, 8'h00, "gated_0F");
    idle_after8(8'h0F, 1'b0, "gated_0F");
  endtask

  task automatic test_back_to_back();
    load_word8(8'hAA, 1'b0);
    shift_frame8(8'hAA, 1'b0, 1, 1'b1, 8'h55, "busyload_AA");
    load_word8(8'h55, 1'b1);
    shift_frame8(8'h55, 1'b1, 1, 1'b0, 8'h00, "doneload_55");
    idle_after8(8'h55, 1'b1, "doneload_55");
  endtask

  task automatic test_reset_midframe();
    logic [7:0] w;
    logic       pt;
    load_word8(8'hFF, 1'b1);
    ser_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_compared++;
      if ({ser_data_l, ser_data_m, busy_l, busy_m} !== 4'hF) begin
        n_mismatched++;
        $display("[TB] FAIL midreset pre bit%0d {serL,serM,busyL,busyM}: actual=%b required=%b",
                 k, {ser_data_l, ser_data_m, busy_l, busy_m}, 4'hF);
      end
      step();
    end
    RST = 1'b1;
    step();
    RST = 1'b0;
    for (int c = 0; c < 12; c++) begin
      n_compared++;
      if ({ser_data_l, ser_data_m, busy_l, busy_m, par_bit_l, par_bit_m, ser_done_l, ser_done_m} !== 8'h00) begin
        n_mismatched++;
        $display("[TB] FAIL midreset post cyc%0d outputs: actual=%b required=%b", c,
                 {ser_data_l, ser_data_m, busy_l, busy_m, par_bit_l, par_bit_m, ser_done_l, ser_done_m}, 8'h00);
      end
      step();
    end
    w  = 8'($urandom);
    pt = 1'($urandom);
    load_word8(w, pt);
    shift_frame8(w, pt, 1, 1'b0, 8'h00, "after_reset");
    idle_after8(w, pt, "after_reset");
  endtask

  task automatic test_random8();
    logic [7:0] w;
    logic       pt;
    int         period;
    bit         noise;
    for (int f = 0; f < 20; f++) begin
      w      = 8'($urandom);
      pt     = 1'($urandom);
      period = int'($urandom_range(1, 3));
      noise  = 1'($urandom);
      ser_en = 1'($urandom);
      load_word8(w, pt);
      shift_frame8(w, pt, period, noise, 8'($urandom), "random8");
      if ($urandom_range(0, 1) == 1) begin
        idle_after8(w, pt, "random8");
      end
    end
    idle_after8(w, pt, "random8_end");
  endtask

  task automatic frame16(input logic [15:0] w, input logic pt, input string tag);
    logic       pe;
    logic [3:0] exp_v;
    pe = parity_of({16'h0, w}, pt);
    p_data16     = w;
    par_typ16    = pt;
    data_valid16 = 1'b1;
    ser_en16     = 1'b1;
    step();
    data_valid16 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      exp_v = {tx_bit({16'h0, w}, 16, k, 1'b0), 1'b1, pe, 1'b0};
      n_compared++;
      if ({ser_data_w, busy_w, par_bit_w, ser_done_w} !== exp_v) begin
        n_mismatched++;
        $display("[TB] FAIL %s bit%0d {ser,busy,par,done}: actual=%b required=%b",
                 tag, k, {ser_data_w, busy_w, par_bit_w, ser_done_w}, exp_v);
      end
      step();
    end
    exp_v = {1'b0, 1'b0, pe, 1'b1};
    n_compared++;
    if ({ser_data_w, busy_w, par_bit_w, ser_done_w} !== exp_v) begin
      n_mismatched++;
      $display("[TB] FAIL %s done-cycle {ser,busy,par,done}: actual=%b required=%b",
               tag, {ser_data_w, busy_w, par_bit_w, ser_done_w}, exp_v);
    end
    step();
  endtask

  task automatic test_width16();
    frame16(16'hA5C3, 1'b0, "w16_A5C3");
    for (int f = 0; f < 3; f++) begin
      frame16(16'($urandom), 1'($urandom), "w16_random");
    end
    ser_en16 = 1'b0;
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    RST          = 1'b1;
    p_data8      = '0;
    data_valid   = 1'b0;
    par_typ      = 1'b0;
    ser_en       = 1'b0;
    p_data16     = '0;
    data_valid16 = 1'b0;
    par_typ16    = 1'b0;
    ser_en16     = 1'b0;
    test_reset();
    test_order_parity();
    test_gated();
    test_back_to_back();
    test_reset_midframe();
    test_random8();
    test_width16();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
